// File: rtl/perceptron_pkg.sv
// Shared types and default sizing for the serial binary perceptron controller.
package perceptron_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DECIDE,
        UPDATE,
        RESP
    } state_t;

    localparam int DEF_N_IN  = 8;
    localparam int DEF_W_W   = 8;
    localparam int DEF_ACC_W = 12;

    localparam int W_MAX = (2 ** (DEF_W_W - 1)) - 1;
    localparam int W_MIN = -(2 ** (DEF_W_W - 1));

endpackage

// File: rtl/perceptron_weight_step.sv
// One weight's +/-1 learning step; passes the weight through when en is low.
// Wraps in two's complement by default, saturates when PERCEPTRON_WEIGHT_SAT_EN is defined.
module perceptron_weight_step
    import perceptron_pkg::*;
#(
    parameter int W_W = DEF_W_W
) (
    input  logic           en,
    input  logic           up,
    input  logic [W_W-1:0] w_cur,
    output logic [W_W-1:0] w_nxt
);

    localparam logic [W_W-1:0] ONE = {{(W_W-1){1'b0}}, 1'b1};

`ifdef PERCEPTRON_WEIGHT_SAT_EN
    localparam logic [W_W-1:0] W_HI = {1'b0, {(W_W-1){1'b1}}};
    localparam logic [W_W-1:0] W_LO = {1'b1, {(W_W-1){1'b0}}};

    always_comb begin
        w_nxt = w_cur;
        if (en) begin
            if (up && (w_cur != W_HI)) begin
                w_nxt = w_cur + ONE;
            end else if (!up && (w_cur != W_LO)) begin
                w_nxt = w_cur - ONE;
            end
        end
    end
`else
    always_comb begin
        w_nxt = w_cur;
        if (en) begin
            w_nxt = up ? (w_cur + ONE) : (w_cur - ONE);
        end
    end
`endif

endmodule

// File: rtl/perceptron_ctrl.sv
// Serial 8-input binary perceptron: one input per cycle, threshold decide, optional learning step.
// Optional build macro PERCEPTRON_WEIGHT_SAT_EN makes weight updates saturate instead of wrap.
module perceptron_ctrl
    import perceptron_pkg::*;
#(
    parameter  int N_IN  = DEF_N_IN,
    parameter  int W_W   = DEF_W_W,
    parameter  int ACC_W = DEF_ACC_W,
    localparam int SEL_W = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [N_IN-1:0]  s_x,
    input  logic             s_label,
    input  logic             s_train,
    input  logic [ACC_W-1:0] threshold,
    output logic             r_valid,
    input  logic             r_ready,
    output logic             r_result,
    output logic             r_error,
    output logic [ACC_W-1:0] r_net,
    input  logic             cfg_we,
    input  logic [SEL_W-1:0] cfg_sel,
    input  logic [W_W-1:0]   cfg_wdata,
    output logic [W_W-1:0]   cfg_rdata,
    output logic             busy,
    output logic [15:0]      update_cnt
);

    state_t state, state_nxt;

    logic [W_W-1:0]   w      [N_IN];
    logic [W_W-1:0]   w_step [N_IN];
    logic [N_IN-1:0]  x_q;
    logic             label_q;
    logic             train_q;
    logic [ACC_W-1:0] thr_q;
    logic [ACC_W-1:0] acc;
    logic [SEL_W-1:0] idx;
    logic [ACC_W-1:0] addend;
    logic             take;
    logic             dec_result;
    logic             dec_err;

    assign s_ready    = (state == IDLE) && !reset;
    assign take       = s_valid && s_ready;
    assign r_valid    = (state == RESP);
    assign busy       = (state != IDLE);
    assign cfg_rdata  = w[cfg_sel];
    assign addend     = x_q[idx] ? {{(ACC_W-W_W){w[idx][W_W-1]}}, w[idx]} : '0;
    assign dec_result = $signed(acc) >= $signed(thr_q);
    assign dec_err    = train_q && (dec_result != label_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = ACCUM;
            ACCUM:   if (idx == SEL_W'(N_IN - 1)) state_nxt = DECIDE;
            DECIDE:  state_nxt = dec_err ? UPDATE : RESP;
            UPDATE:  state_nxt = RESP;
            RESP:    if (r_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q        <= '0;
            label_q    <= 1'b0;
            train_q    <= 1'b0;
            thr_q      <= '0;
            acc        <= '0;
            idx        <= '0;
            r_result   <= 1'b0;
            r_error    <= 1'b0;
            r_net      <= '0;
            update_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        x_q     <= s_x;
                        label_q <= s_label;
                        train_q <= s_train;
                        thr_q   <= threshold;
                        acc     <= '0;
                        idx     <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc + addend;
                    idx <= idx + SEL_W'(1);
                end
                DECIDE: begin
                    r_result <= dec_result;
                    r_error  <= dec_err;
                    r_net    <= acc;
                end
                UPDATE: begin
                    if (update_cnt != 16'hFFFF) begin
                        update_cnt <= update_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Config writes land only while idle, so a write coinciding with a handshake is seen by that sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_IN; i++) begin
                w[i] <= '0;
            end
        end else if ((state == IDLE) && cfg_we) begin
            w[cfg_sel] <= cfg_wdata;
        end else if (state == UPDATE) begin
            for (int i = 0; i < N_IN; i++) begin
                w[i] <= w_step[i];
            end
        end
    end

    for (genvar g = 0; g < N_IN; g++) begin : g_step
        perceptron_weight_step #(.W_W(W_W)) u_step (
            .en    (x_q[g]),
            .up    (label_q),
            .w_cur (w[g]),
            .w_nxt (w_step[g])
        );
    end

endmodule

// File: tb/tb_perceptron_ctrl.sv
// Bench for perceptron_ctrl: directed scenarios plus randomized samples against a behavioural model.
module tb_perceptron_ctrl;
    import perceptron_pkg::*;

    localparam int N_IN  = DEF_N_IN;
    localparam int W_W   = DEF_W_W;
    localparam int ACC_W = DEF_ACC_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             s_valid, s_ready, s_label, s_train;
    logic [N_IN-1:0]  s_x;
    logic [ACC_W-1:0] threshold;
    logic             r_valid, r_ready, r_result, r_error;
    logic [ACC_W-1:0] r_net;
    logic             cfg_we;
    logic [2:0]       cfg_sel;
    logic [W_W-1:0]   cfg_wdata, cfg_rdata;
    logic             busy;
    logic [15:0]      update_cnt;

    perceptron_ctrl dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_label(s_label),
        .s_train(s_train), .threshold(threshold),
        .r_valid(r_valid), .r_ready(r_ready), .r_result(r_result),
        .r_error(r_error), .r_net(r_net),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .busy(busy), .update_cnt(update_cnt)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    logic chk_en   = 1'b0;

    // Behavioural model state.
    int   mw [N_IN];
    int   mcnt;
    logic exp_busy, exp_rvalid, exp_res, exp_err;
    int   exp_net;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic int model_net(input logic [N_IN-1:0] x);
        int s = 0;
        for (int i = 0; i < N_IN; i++) if (x[i]) s += mw[i];
        return s;
    endfunction

    task automatic model_update(input logic [N_IN-1:0] x, input logic lab);
        for (int i = 0; i < N_IN; i++) begin
            if (x[i]) begin
                int v;
                v = mw[i] + (lab ? 1 : -1);
`ifdef PERCEPTRON_WEIGHT_SAT_EN
                if (v > W_MAX) v = W_MAX;
                if (v < W_MIN) v = W_MIN;
`else
                if (v > W_MAX) v -= 256;
                if (v < W_MIN) v += 256;
`endif
                mw[i] = v;
            end
        end
        if (mcnt != 65535) mcnt++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_IN; i++) mw[i] = 0;
        mcnt       = 0;
        exp_busy   = 1'b0;
        exp_rvalid = 1'b0;
    endtask

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, exp_busy);
            chk("s_ready", s_ready, (!exp_busy && !reset));
            chk("r_valid", r_valid, exp_rvalid);
            if (exp_rvalid) begin
                chk("r_net", $signed(r_net), exp_net);
                chk("r_result", r_result, exp_res);
                chk("r_error", r_error, exp_err);
            end
            chk("cfg_rdata", $signed(cfg_rdata), mw[cfg_sel]);
            chk("update_cnt", update_cnt, mcnt);
        end
    end

    task automatic cfg_write(input int sel, input int val);
        cfg_we    = 1'b1;
        cfg_sel   = sel[2:0];
        cfg_wdata = val[7:0];
        @(posedge clk); #1;
        cfg_we    = 1'b0;
        mw[sel]   = val;
    endtask

    task automatic rb(input string nm, input int sel, input int exp);
        cfg_sel = sel[2:0];
        #1;
        chk(nm, $signed(cfg_rdata), exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        model_reset();
        reset = 1'b0;
    endtask

    // Called #1 after an edge with the DUT idle. Returns DUT outputs seen at the first r_valid cycle.
    task automatic run_sample(input logic [N_IN-1:0] x, input logic lab, input logic trn,
                              input int thr, input int hold, input int abort_at, input logic poke,
                              input logic cw, input int cw_sel, input int cw_val,
                              output int net_o, output int res_o, output int err_o, output int lat_o);
        int lat;
        int net;
        logic res, err;
        net_o = 0; res_o = 0; err_o = 0; lat_o = 0;
        s_x = x; s_label = lab; s_train = trn; threshold = thr[ACC_W-1:0]; s_valid = 1'b1;
        if (cw) begin
            cfg_we = 1'b1; cfg_sel = cw_sel[2:0]; cfg_wdata = cw_val[7:0];
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        cfg_we  = 1'b0;
        if (cw) mw[cw_sel] = cw_val;
        net = model_net(x);
        res = (net >= thr);
        err = trn && (res != lab);
        lat = N_IN + 2 + (err ? 1 : 0);
        lat_o    = lat;
        exp_busy = 1'b1;
        for (int t = 1; t < lat; t++) begin
            if (t == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                model_reset();
                reset = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        exp_net = net; exp_res = res; exp_err = err;
        exp_rvalid = 1'b1;
        if (err) model_update(x, lab);
        net_o = $signed(r_net); res_o = r_result; err_o = r_error;
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                s_valid   = 1'b1;
                cfg_we    = 1'b1;
                cfg_sel   = 3'($urandom_range(0, 7));
                cfg_wdata = 8'($urandom);
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        cfg_we  = 1'b0;
        r_ready = 1'b1;
        @(posedge clk); #1;
        r_ready    = 1'b0;
        exp_rvalid = 1'b0;
        exp_busy   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int net, res, err, lat;
        reset = 1'b1; s_valid = 1'b0; s_x = '0; s_label = 1'b0; s_train = 1'b0;
        threshold = '0; r_ready = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_r_net", $signed(r_net), 0);
        chk("rst_r_result", r_result, 0);
        chk("rst_r_error", r_error, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Zero weights, train on all-ones: error, every weight steps to +1.
        run_sample(8'hFF, 1'b1, 1'b1, 1, 0, 0, 1'b0, 1'b0, 0, 0, net, res, err, lat);
        chk("t2_net", net, 0); chk("t2_res", res, 0); chk("t2_err", err, 1); chk("t2_lat", lat, 11);
        for (int i = 0; i < N_IN; i++) rb("t2_w", i, 1);
        chk("t2_cnt", update_cnt, 1);
        run_sample(8'hFF, 1'b1, 1'b1, 1, 0, 0, 1'b0, 1'b0, 0, 0, net, res, err, lat);
        chk("t2b_net", net, 8); chk("t2b_res", res, 1); chk("t2b_err", err, 0);
        chk("t2b_cnt", update_cnt, 1);

        // Weights 1..8, inference on x=0x05.
        for (int i = 0; i < N_IN; i++) cfg_write(i, i + 1);
        run_sample(8'h05, 1'b0, 1'b0, 4, 0, 0, 1'b0, 1'b0, 0, 0, net, res, err, lat);
        chk("t1_net", net, 4); chk("t1_res", res, 1); chk("t1_err", err, 0); chk("t1_lat", lat, 10);
        rb("t1_w0", 0, 1); rb("t1_w2", 2, 3);

        // Signed threshold compare with all weights -1.
        for (int i = 0; i < N_IN; i++) cfg_write(i, -1);
        run_sample(8'hFF, 1'b0, 1'b0, -8, 0, 0, 1'b0, 1'b0, 0, 0, net, res, err, lat);
        chk("t3_net", net, -8); chk("t3_res", res, 1);
        run_sample(8'hFF, 1'b0, 1'b0, -7, 0, 0, 1'b0, 1'b0, 0, 0, net, res, err, lat);
        chk("t3b_res", res, 0);

        // Result held for 5 cycles while the source and config path poke at the DUT.
        run_sample(8'h3C, 1'b1, 1'b0, 0, 5, 0, 1'b1, 1'b0, 0, 0, net, res, err, lat);
        chk("t4_net", net, -4);

        // Weight at the positive limit stepped up.
        do_reset();
        cfg_write(3, 127);
        run_sample(8'h08, 1'b1, 1'b1, 200, 0, 0, 1'b0, 1'b0, 0, 0, net, res, err, lat);
        chk("t5_net", net, 127); chk("t5_err", err, 1);
`ifdef PERCEPTRON_WEIGHT_SAT_EN
        rb("t5_w3", 3, 127);
`else
        rb("t5_w3", 3, -128);
`endif
        chk("t5_cnt", update_cnt, 1);

        // Reset during the fourth accumulate cycle aborts the sample.
        run_sample(8'hFF, 1'b1, 1'b1, 500, 0, 4, 1'b0, 1'b0, 0, 0, net, res, err, lat);
        chk("t6_busy", busy, 0); chk("t6_rvalid", r_valid, 0); chk("t6_cnt", update_cnt, 0);
        for (int i = 0; i < N_IN; i++) rb("t6_w", i, 0);
        run_sample(8'hFF, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0, net, res, err, lat);
        chk("t6b_net", net, 0); chk("t6b_res", res, 1);

        // Randomized samples, occasionally with a write coinciding with the handshake.
        for (int k = 0; k < 30; k++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int j = 0; j < nw; j++)
                cfg_write($urandom_range(0, 7), $urandom_range(0, 255) - 128);
            run_sample(8'($urandom), 1'($urandom), 1'($urandom),
                       $urandom_range(0, 600) - 300, $urandom_range(0, 3), 0, 1'($urandom),
                       1'($urandom), $urandom_range(0, 7), $urandom_range(0, 255) - 128,
                       net, res, err, lat);
        end

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/perceptron_ctrl.md
Name: perceptron_ctrl

Overview:
Sequencing controller for the 8-input binary perceptron. It accepts one sample per valid/ready handshake and accumulates net input serially, one input per cycle, against a signed weight bank. It then compares the sum with a signed threshold and, in train mode, applies the perceptron learning rule (step ±1) before returning the result. It sits between the sample source and the result consumer, owns the weight register file, and gives the config path weight write and readback.

Parameters:
N_IN, 8, number of binary inputs and weights
W_W, 8, signed weight width
ACC_W, 12, signed accumulator/threshold width; must be ≥ W_W + clog2(N_IN) + 1

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
s_valid  in  1  sample valid
s_ready  out  1  controller ready for sample (high only in IDLE)
s_x  in  N_IN  binary input vector
s_label  in  1  target output for training
s_train  in  1  1 = update weights on error, 0 = inference only
threshold  in  ACC_W  signed activation threshold, sampled at handshake
r_valid  out  1  result valid
r_ready  in  1  consumer accepts result
r_result  out  1  1 when net ≥ threshold (signed)
r_error  out  1  s_train && (r_result != s_label)
r_net  out  ACC_W  signed net input of the sample
cfg_we  in  1  weight write strobe, honoured only in IDLE
cfg_sel  in  clog2(N_IN)  weight index for write/readback
cfg_wdata  in  W_W  weight write data
cfg_rdata  out  W_W  combinational readback of weight[cfg_sel]
busy  out  1  state != IDLE
update_cnt  out  16  count of weight-update events since reset, saturates at 0xFFFF

Behaviour:
- Reset (sync, active-high) sets: state=IDLE, all weights=0, acc=0, index=0, r_valid=0, r_result=0, r_error=0, r_net=0, update_cnt=0.
- s_ready is forced to 0 while reset is high. Reset mid-operation aborts the sample; no r_valid is produced for it.
- FSM states:
  - IDLE: s_ready=1. On s_valid&&s_ready, capture s_x, s_label, s_train and threshold; clear acc and index; go to ACCUM.
  - ACCUM: N_IN cycles, index 0..N_IN-1. acc += x[index] ? sext(w[index]) : 0. After index N_IN-1, go to DECIDE.
  - DECIDE: result = (acc ≥ thr), signed compare. err = train && (result != label). Register r_result, r_error and r_net=acc. If err, go to UPDATE; else go to RESP.
  - UPDATE: one cycle. For every i with x[i]=1: w[i] += (label ? +1 : -1). update_cnt++ (saturating). Go to RESP.
  - RESP: r_valid=1. r_result, r_error and r_net stay stable until r_valid&&r_ready, then go to IDLE. There is no bypass: a new sample is accepted at the earliest one cycle after the result handshake.
- Latency: handshake at cycle 0; r_valid first high at cycle N_IN+2 (no update) or N_IN+3 (update).
- Arithmetic:
  - acc never overflows, by the ACC_W rule.
  - Weight update wraps in two's complement at W_W bits unless the optional feature below is compiled in.
- Config writes:
  - cfg_we in IDLE writes w[cfg_sel] at the edge.
  - If cfg_we coincides with the sample handshake, the write lands first and the sample uses the new weight.
  - cfg_we outside IDLE is ignored.
  - cfg_rdata is valid in every state.
- All-zero s_x: net=0; an update step in this case changes no weights but still increments update_cnt.

Optional Feature:
PERCEPTRON_WEIGHT_SAT_EN
- Defined: weight updates saturate to [-2^(W_W-1), 2^(W_W-1)-1].
- Undefined: updates wrap modulo 2^W_W.
- update_cnt behaviour is identical either way.

Decomposition:
- Package perceptron_pkg holds:
  - state enum {IDLE, ACCUM, DECIDE, UPDATE, RESP}
  - default N_IN, W_W and ACC_W constants
  - W_MAX / W_MIN constants
- One sub-module, perceptron_weight_step: per-weight ±1 adder with enable and conditional saturation, instantiated N_IN times.

Test Plan:
- Weights w0..w7=1..8 via cfg, s_x=0x05, threshold=4, infer -> r_net=4, r_result=1, r_error=0; r_valid 10 cycles after handshake; no weight change.
- Weights all 0, threshold=1, s_x=0xFF, label=1, train=1 -> r_net=0, r_result=0, r_error=1; r_valid at cycle 11; all weights=+1; update_cnt=1. Repeat the same sample -> r_net=8, r_result=1, no update, update_cnt=1.
- Weights all -1, s_x=0xFF, threshold=-8 -> r_net=-8, r_result=1 (signed compare). Same sample with threshold=-7 -> r_result=0.
- Hold r_ready=0 for 5 cycles in RESP -> r_valid and outputs stable, s_ready=0, a concurrent s_valid is not accepted, a cfg_we write is ignored (cfg_rdata unchanged).
- w3=127, s_x=0x08, label=1, train=1, threshold=200 -> update gives w3=-128 without the macro and w3=127 with PERCEPTRON_WEIGHT_SAT_EN; update_cnt=1 in both builds.
- Assert reset on cycle 4 of ACCUM -> next cycle busy=0, r_valid=0, all weights read back 0, update_cnt=0; no result produced; a new sample is accepted after reset deasserts.
